booth_result_display: RTL and testbench



---
 rtl/booth_result_display.sv | 205 ++++++++++++++++++++
 tb/tb_booth_result_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_result_display.sv
// booth_result_display
// Consumer of the 8-bit Booth multiplier result. On each rising edge of
// `over` (while not already converting) the signed 16-bit `answer` is
// captured, its magnitude is converted to five BCD digits by a sequential
// double-dabble (one shift per clock, 16 clocks), and the result is shown
// on a multiplexed, active-low 8-digit 7-segment display.
//
// Ports:
//   clk    - system clock, all logic on the rising edge
//   rst    - synchronous active-high reset
//   answer - signed two's-complement product from the multiplier
//   over   - multiplier done level; its rising edge marks answer valid
//   busy   - high while a capture/conversion is in progress
//   valid  - high once a converted result is being displayed
//   an     - digit enables, active-low, one low at a time (an[7:6] unused)
//   seg    - segments {g,f,e,d,c,b,a}, active-low
module booth_result_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] answer,
  input  logic        over,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t       state_q, state_d;
  logic         over_d_q, over_d_d;
  logic         sign_q, sign_d;
  logic [15:0]  mag_q, mag_d;
  logic [19:0]  bcd_q, bcd_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic [19:0]  disp_bcd_q, disp_bcd_d;
  logic         disp_neg_q, disp_neg_d;
  logic [CW-1:0] ref_q, ref_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   an_q, an_d;
  logic [6:0]   seg_q, seg_d;

  logic         capture;
  logic [19:0]  bcd_adj;
  logic [35:0]  shifted;
  logic [4:0]   lz;
  logic [3:0]   nib;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Capture/convert FSM. The double-dabble step adjusts every nibble >= 5
  // before the shift; the 16th shift lands directly in the display
  // registers so a partially converted value is never visible.
  always_comb begin
    state_d    = state_q;
    over_d_d   = over;
    sign_d     = sign_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;

    capture = over && !over_d_q && (state_q != CONVERT);

    for (int i = 0; i < 5; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
    shifted = {bcd_adj[18:0], mag_q, 1'b0};

    case (state_q)
      IDLE, DONE: begin
        if (capture) begin
          sign_d  = answer[15];
          // 0x8000 negates to itself, which read as unsigned is 32768.
          mag_d   = answer[15] ? (~answer + 16'd1) : answer;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = shifted[35:16];
        mag_d = shifted[15:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          disp_bcd_d = shifted[35:16];
          disp_neg_d = sign_q && (shifted[35:16] != 20'd0);
          busy_d     = 1'b0;
          valid_d    = 1'b1;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit scan and segment decode. an/seg are built from the next-state
  // index and display values so both outputs move together on one edge.
  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == REF_MAX) begin
      ref_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    an_d = 8'hFF;
    an_d[idx_d] = 1'b0;

    // lz[k] is set when digit k and all higher digits are zero.
    lz[4] = (disp_bcd_d[19:16] == 4'd0);
    for (int k = 3; k >= 0; k--) begin
      lz[k] = lz[k+1] && (disp_bcd_d[4*k +: 4] == 4'd0);
    end

    nib   = 4'd0;
    seg_d = 7'h7F;
    case (idx_d)
      3'd0: nib = disp_bcd_d[3:0];
      3'd1: nib = disp_bcd_d[7:4];
      3'd2: nib = disp_bcd_d[11:8];
      3'd3: nib = disp_bcd_d[15:12];
      3'd4: nib = disp_bcd_d[19:16];
      default: nib = 4'd0;
    endcase

    if (valid_d) begin
      if (idx_d == 3'd5) begin
        seg_d = disp_neg_d ? 7'b0111111 : 7'b1111111;
      end else if (BLANK_LZ && (idx_d != 3'd0) && lz[idx_d]) begin
        seg_d = 7'h7F;
      end else begin
        seg_d = seg_of(nib);
      end
    end
  end

  // State register; reset aborts any conversion and blanks the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      over_d_q   <= 1'b0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      ref_q      <= '0;
      idx_q      <= '0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
    end else begin
      state_q    <= state_d;
      over_d_q   <= over_d_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      ref_q      <= ref_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_booth_result_display.sv
// tb_booth_result_display
// Directed bench for booth_result_display with a fast scan (REFRESH_DIV=4).
// Expected displays come from an arithmetic model (divide/modulo) pushed to
// a scoreboard when a result is launched and popped when conversion ends.
module tb_booth_result_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] answer;
  logic        over;
  logic        busy;
  logic        valid;
  logic [7:0]  an;
  logic [6:0]  seg;

  int tests = 0;
  int fails = 0;

  logic [5:0][6:0] sb_q[$];
  logic [5:0][6:0] shown;

  booth_result_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .answer(answer), .over(over),
    .busy(busy), .valid(valid), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'h40; 1: enc = 7'h79; 2: enc = 7'h24; 3: enc = 7'h30;
      4: enc = 7'h19; 5: enc = 7'h12; 6: enc = 7'h02; 7: enc = 7'h78;
      8: enc = 7'h00; 9: enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  function automatic logic [5:0][6:0] model(input logic [15:0] a);
    logic [5:0][6:0] r;
    int m, d, div;
    bit lz;
    m  = a[15] ? 65536 - int'(a) : int'(a);
    lz = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      div = 1;
      for (int j = 0; j < k; j++) div = div * 10;
      d  = (m / div) % 10;
      lz = lz && (d == 0);
      r[k] = (lz && k != 0) ? 7'h7F : enc(d);
    end
    r[5] = (a[15] && m != 0) ? 7'h3F : 7'h7F;
    return r;
  endfunction

  // Returns the digit index currently enabled, or -1 if none/illegal.
  function automatic int cur_digit(input logic [7:0] a);
    logic [7:0] m;
    cur_digit = -1;
    for (int k = 0; k < 6; k++) begin
      m = 8'h01 << k;
      if (a == ~m) cur_digit = k;
    end
  endfunction

  // Launch a result on a fresh over edge, verify the busy window and that
  // the old value stays displayed throughout, then check the new display.
  task automatic applyStimulus(input logic [15:0] a);
    int n, k;
    answer = a;
    over   = 1'b0;
    tick();
    over = 1'b1;
    sb_q.push_back(model(a));
    tick();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      k = cur_digit(an);
      if (k >= 0) checkOutput("hold_old", {25'd0, seg}, {25'd0, shown[k]});
      n++;
      tick();
    end
    checkOutput("busy_cycles", n, 16);
    checkOutput("valid_after", {31'd0, valid}, 32'd1);
    checkDigits();
  endtask

  task automatic checkDigits();
    logic [5:0][6:0] exp;
    logic [5:0] seen;
    int k;
    checkOutput("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
    if (sb_q.size() != 0) begin
      exp  = sb_q.pop_front();
      seen = '0;
      for (int n = 0; n < 40 && seen != 6'h3F; n++) begin
        k = cur_digit(an);
        if (k >= 0 && !seen[k]) begin
          checkOutput($sformatf("digit%0d", k), {25'd0, seg}, {25'd0, exp[k]});
          seen[k] = 1'b1;
        end
        tick();
      end
      checkOutput("scan_cover", {26'd0, seen}, 32'h3F);
      shown = exp;
    end
  endtask

  initial begin
    logic [7:0] prev, exp_an, m;
    int cnt, n;
    bit found;

    rst = 1'b1; over = 1'b0; answer = 16'h3F01;
    for (int i = 0; i < 6; i++) shown[i] = 7'h7F;
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_an", {24'd0, an}, 32'hFF);
    checkOutput("rst_seg", {25'd0, seg}, 32'h7F);

    // Idle before any result: scan runs but every digit is blank.
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checkOutput("idle_blank", {23'd0, busy, valid, an[7:6], seg},
                  {23'd0, 1'b0, 1'b0, 2'b11, 7'h7F});
    end

    // Scan order and hold time.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = an;
      tick();
      if (an == 8'hFE && prev != 8'hFE) found = 1'b1;
    end
    checkOutput("scan_align", {31'd0, found}, 32'd1);
    for (int j = 0; j < 12; j++) begin
      m = 8'h01 << (j % 6);
      exp_an = ~m;
      cnt = 0;
      while (an == exp_an && cnt < 10) begin
        cnt++;
        tick();
      end
      checkOutput($sformatf("scan_hold_%0h", exp_an), cnt, 4);
    end

    applyStimulus(16'h3F01);
    applyStimulus(16'hC080);
    applyStimulus(16'h4000);
    applyStimulus(16'h0000);
    applyStimulus(16'h8000);

    // over is still high here: holding it must not retrigger.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy === 1'b1) cnt++;
    end
    checkOutput("held_no_retrigger", cnt, 0);

    // A second edge during CONVERT is dropped; first value completes.
    answer = 16'hFF85;
    over   = 1'b0;
    tick();
    over = 1'b1;
    sb_q.push_back(model(16'hFF85));
    tick();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n == 4) over = 1'b0;
      if (n == 6) begin over = 1'b1; answer = 16'h1234; end
      n++;
      tick();
    end
    checkOutput("ignored_busy_cycles", n, 16);
    checkDigits();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) cnt++;
    end
    checkOutput("ignored_not_queued", cnt, 0);

    // Reset in the middle of a conversion.
    answer = 16'h2710;
    over   = 1'b0;
    tick();
    over = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    rst  = 1'b1;
    over = 1'b0;
    tick();
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_valid", {31'd0, valid}, 32'd0);
    checkOutput("abort_seg", {25'd0, seg}, 32'h7F);
    checkOutput("abort_an", {24'd0, an}, 32'hFF);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) shown[i] = 7'h7F;
    tick();
    applyStimulus(16'hD8F0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
